// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and defaults for the I/D cacheline arbiter.
package arb_types;

  localparam int unsigned DEFAULT_LINE_WIDTH  = 256;
  localparam int unsigned DEFAULT_ADDR_WIDTH  = 32;
  localparam int unsigned DEFAULT_MAX_D_BURST = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

endpackage : arb_types

// File: rtl/cacheline_arbiter.sv
// Non-preemptive arbiter of I-cache and D-cache line transfers onto one memory port.
// D-cache wins ties unless the I-cache has waited through MAX_D_BURST D grants.
module cacheline_arbiter
  import arb_types::*;
#(
  parameter int unsigned LINE_WIDTH  = DEFAULT_LINE_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned MAX_D_BURST = DEFAULT_MAX_D_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int unsigned      CNT_W   = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_BURST);

  arb_state_t            state_q, state_d;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_write_q, op_write_d;

  logic d_req;
  logic i_forced;

  assign d_req    = d_read | d_write;
  assign i_forced = i_read & (starve_cnt_q == CNT_MAX);

  // State, starvation counter and grant latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_write_q   <= op_write_d;
    end
  end

  // Next-state and grant decision; requests are only looked at in IDLE
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_write_d   = op_write_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !i_forced) begin
          state_d    = SERVE_D;
          addr_d     = d_addr;
          op_write_d = d_write;
          if (d_write) wdata_d = d_wdata;
          if (i_read && (starve_cnt_q != CNT_MAX)) starve_cnt_d = CNT_W'(starve_cnt_q + 1'b1);
        end else if (i_read) begin
          state_d      = SERVE_I;
          addr_d       = i_addr;
          op_write_d   = 1'b0;
          starve_cnt_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes follow the registered state; responses pass memory data straight through
  always_comb begin
    pmem_read  = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~op_write_q);
    pmem_write = (state_q == SERVE_D) & op_write_q;
    pmem_addr  = addr_q;
    pmem_wdata = wdata_q;
    i_resp     = (state_q == SERVE_I) & pmem_resp;
    d_resp     = (state_q == SERVE_D) & pmem_resp;
    i_rdata    = i_resp ? pmem_rdata : '0;
    d_rdata    = d_resp ? pmem_rdata : '0;
  end

endmodule : cacheline_arbiter

// File: tb/tb_cacheline_arbiter.sv
// Directed bench for cacheline_arbiter: priority, starvation bound, grant latching,
// async reset mid-transfer and spurious memory responses.
module tb_cacheline_arbiter;
  import arb_types::*;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;

  int checks = 0;
  int errors = 0;
  int i_resp_cnt = 0;
  int d_resp_cnt = 0;
  int i_base, d_base;

  cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MAX_D_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_resp) i_resp_cnt <= i_resp_cnt + 1;
    if (d_resp) d_resp_cnt <= d_resp_cnt + 1;
  end

  always @(posedge clk) begin
    if (!rst) assert (!(d_read && d_write)) else $error("illegal d_read & d_write together");
  end

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise pmem_resp for exactly one sampled edge; caller checks in between
  task automatic mem_resp_start(input logic [LW-1:0] line);
    pmem_rdata = line;
    pmem_resp  = 1'b1;
    #1;
  endtask

  task automatic mem_resp_end();
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
  endtask

  logic [LW-1:0] line_a5, line_3c, line_ff, line_i1, line_d1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    line_a5 = {32{8'hA5}};
    line_3c = {32{8'h3C}};
    line_ff = {32{8'hFF}};
    line_i1 = {8{32'h1111_0001}};
    line_d1 = {8{32'hDDDD_0002}};
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
    #1;
    check("rst_pmem_read", LW'(pmem_read), LW'(0));
    check("rst_pmem_write", LW'(pmem_write), LW'(0));
    check("rst_pmem_addr", LW'(pmem_addr), LW'(0));
    check("rst_pmem_wdata", pmem_wdata, LW'(0));
    check("rst_resps", LW'({i_resp, d_resp}), LW'(0));
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: lone I read, memory answers after 3 cycles
    i_base = i_resp_cnt;
    i_read = 1'b1; i_addr = 32'h0000_1000;
    tick();
    check("t1_pmem_read", LW'(pmem_read), LW'(1));
    check("t1_pmem_addr", LW'(pmem_addr), LW'(32'h1000));
    check("t1_pmem_write", LW'(pmem_write), LW'(0));
    tick(); tick();
    check("t1_hold_read", LW'(pmem_read), LW'(1));
    check("t1_no_early_resp", LW'(i_resp), LW'(0));
    mem_resp_start(line_i1);
    check("t1_i_resp", LW'(i_resp), LW'(1));
    check("t1_i_rdata", i_rdata, line_i1);
    check("t1_no_d_resp", LW'(d_resp), LW'(0));
    mem_resp_end();
    check("t1_done_strobe", LW'(pmem_read), LW'(0));
    check("t1_done_resp", LW'(i_resp), LW'(0));
    check("t1_rdata_zero", i_rdata, LW'(0));
    i_read = 1'b0;
    tick();
    check("t1_resp_count", LW'(i_resp_cnt - i_base), LW'(1));

    // 2: simultaneous I read + D write, D wins
    i_base = i_resp_cnt; d_base = d_resp_cnt;
    i_read = 1'b1; i_addr = 32'h0000_2000;
    d_write = 1'b1; d_addr = 32'h0000_3000; d_wdata = line_a5;
    tick();
    check("t2_pmem_write", LW'(pmem_write), LW'(1));
    check("t2_pmem_read", LW'(pmem_read), LW'(0));
    check("t2_d_addr", LW'(pmem_addr), LW'(32'h3000));
    check("t2_wdata", pmem_wdata, line_a5);
    mem_resp_start(line_d1);
    check("t2_d_resp", LW'(d_resp), LW'(1));
    check("t2_no_i_resp", LW'(i_resp), LW'(0));
    mem_resp_end();
    d_write = 1'b0;
    tick();
    check("t2_idle_gap", LW'(pmem_read | pmem_write), LW'(0));
    tick();
    check("t2_i_read", LW'(pmem_read), LW'(1));
    check("t2_i_addr", LW'(pmem_addr), LW'(32'h2000));
    mem_resp_start(line_i1);
    check("t2_i_rdata", i_rdata, line_i1);
    mem_resp_end();
    i_read = 1'b0;
    tick();
    check("t2_i_count", LW'(i_resp_cnt - i_base), LW'(1));
    check("t2_d_count", LW'(d_resp_cnt - d_base), LW'(1));

    // 3: D reads back-to-back while I waits: four D grants then a forced I grant
    i_base = i_resp_cnt; d_base = d_resp_cnt;
    i_read = 1'b1; i_addr = 32'h0000_4000;
    d_read = 1'b1; d_addr = 32'h0000_5000;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("t3_d_grant_addr", LW'(pmem_addr), LW'(32'h5000));
      mem_resp_start(line_d1);
      check("t3_d_resp", LW'(d_resp), LW'(1));
      mem_resp_end();
      tick();
    end
    check("t3_starve_full", LW'(dut.starve_cnt_q), LW'(4));
    tick();
    check("t3_forced_i_addr", LW'(pmem_addr), LW'(32'h4000));
    check("t3_forced_i_read", LW'(pmem_read), LW'(1));
    check("t3_starve_clear", LW'(dut.starve_cnt_q), LW'(0));
    mem_resp_start(line_i1);
    check("t3_i_resp", LW'(i_resp), LW'(1));
    mem_resp_end();
    i_read = 1'b0; d_read = 1'b0;
    tick();
    check("t3_d_count", LW'(d_resp_cnt - d_base), LW'(4));
    check("t3_i_count", LW'(i_resp_cnt - i_base), LW'(1));

    // 4: D inputs change after grant; latched values must hold
    d_write = 1'b1; d_addr = 32'h0000_6000; d_wdata = line_3c;
    tick();
    d_addr = 32'h0000_7000; d_wdata = line_ff;
    tick();
    check("t4_addr_latched", LW'(pmem_addr), LW'(32'h6000));
    check("t4_wdata_latched", pmem_wdata, line_3c);
    check("t4_write_held", LW'(pmem_write), LW'(1));
    mem_resp_start(line_d1);
    check("t4_d_resp", LW'(d_resp), LW'(1));
    mem_resp_end();
    d_write = 1'b0;
    tick();

    // 5: async reset during SERVE_I
    i_base = i_resp_cnt;
    i_read = 1'b1; i_addr = 32'h0000_8000;
    tick();
    check("t5_serving", LW'(pmem_read), LW'(1));
    rst = 1'b1;
    #1;
    check("t5_strobe_drop", LW'(pmem_read), LW'(0));
    check("t5_state_idle", LW'(dut.state_q), LW'(IDLE));
    i_read = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    mem_resp_start(line_i1);
    check("t5_no_i_resp", LW'(i_resp), LW'(0));
    check("t5_i_rdata_zero", i_rdata, LW'(0));
    mem_resp_end();
    check("t5_state_after", LW'(dut.state_q), LW'(IDLE));
    check("t5_i_count", LW'(i_resp_cnt - i_base), LW'(0));

    // 6: spurious pmem_resp while idle
    i_base = i_resp_cnt; d_base = d_resp_cnt;
    mem_resp_start(line_ff);
    check("t6_no_resp", LW'({i_resp, d_resp}), LW'(0));
    check("t6_d_rdata_zero", d_rdata, LW'(0));
    mem_resp_end();
    check("t6_state_idle", LW'(dut.state_q), LW'(IDLE));
    check("t6_no_strobe", LW'(pmem_read | pmem_write), LW'(0));
    check("t6_counts", LW'((i_resp_cnt - i_base) + (d_resp_cnt - d_base)), LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cacheline_arbiter
